// File: rtl/iobus_uart_tx.sv
// iobus_uart_tx: MMIO UART transmitter on the OTTER IOBUS.
// Bytes written to TXDATA are queued in a small FIFO and sent 8N1 on UART_TXD.
// STATUS exposes busy/full/empty/overflow/count; CTRL holds irq_en and
// clears overflow. IRQ is a level that is high while enabled and the
// transmitter is idle with nothing queued.
//
// Transmit FSM states:
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (low) for DIV cycles
//   DATA  | eight data bits, LSB first, DIV cycles each
//   STOP  | stop bit (high) for DIV cycles, then chain or idle
module iobus_uart_tx #(
  parameter int          CLK_RATE   = 50,
  parameter int          BAUD       = 115200,
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RD_DATA,
  output logic        UART_TXD,
  output logic        IRQ
);

  // Rounded clock cycles per bit.
  localparam int DIV = (CLK_RATE * 1000000 + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int PW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE_B   = CW'(1);
  localparam logic [PW-1:0] ONE_P   = PW'(1);
  localparam logic [PW:0]   ONE_C   = (PW + 1)'(1);
  localparam logic [PW:0]   DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [3:0]    count_nib;

  logic overflow;
  logic irq_en;

  logic sel_tx, sel_status, sel_ctrl;
  logic wr_tx, wr_ctrl;
  logic empty, full, busy, baud_tc;
  logic pop, push;

  assign sel_tx     = (IOBUS_ADDR == BASE_ADDR);
  assign sel_status = (IOBUS_ADDR == BASE_ADDR + 32'd4);
  assign sel_ctrl   = (IOBUS_ADDR == BASE_ADDR + 32'd8);
  assign wr_tx      = IOBUS_WR & sel_tx;
  assign wr_ctrl    = IOBUS_WR & sel_ctrl;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign baud_tc = (baud_cnt == '0);

  // The FSM takes a byte when idle, or at the last stop-bit cycle so frames chain.
  assign pop  = ~empty & ((state == IDLE) | ((state == STOP) & baud_tc));
  // A full FIFO still accepts a byte if a slot frees up in the same cycle.
  assign push = wr_tx & (~full | pop);

  assign busy      = (state != IDLE) | ~empty;
  assign IRQ       = irq_en & ~busy;
  assign count_nib = 4'(count);

  // Register read mux, purely combinational from address and current state.
  always_comb begin
    RD_DATA = '0;
    if (sel_status)
      RD_DATA = {24'b0, count_nib, overflow, empty, full, busy};
    else if (sel_ctrl)
      RD_DATA = {30'b0, 1'b0, irq_en};
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge CLK) begin
    if (push)
      fifo_mem[wr_ptr] <= IOBUS_OUT[7:0];
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + ONE_P;
      if (pop)
        rd_ptr <= rd_ptr + ONE_P;
      case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

  // Control register and sticky overflow; a new overflow beats a clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl)
        irq_en <= IOBUS_OUT[0];
      if (wr_tx & full & ~pop)
        overflow <= 1'b1;
      else if (wr_ctrl & IOBUS_OUT[1])
        overflow <= 1'b0;
    end
  end

  // Serializer FSM with a down-counting baud timer and registered line output.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      UART_TXD <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          UART_TXD <= 1'b1;
          if (pop) begin
            shift    <= fifo_mem[rd_ptr];
            baud_cnt <= DIV_M1;
            UART_TXD <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_tc) begin
            baud_cnt <= DIV_M1;
            bit_idx  <= '0;
            UART_TXD <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - ONE_B;
          end
        end
        DATA: begin
          if (baud_tc) begin
            baud_cnt <= DIV_M1;
            if (bit_idx == 3'd7) begin
              UART_TXD <= 1'b1;
              state    <= STOP;
            end else begin
              shift    <= {1'b0, shift[7:1]};
              UART_TXD <= shift[1];
              bit_idx  <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - ONE_B;
          end
        end
        STOP: begin
          if (baud_tc) begin
            if (pop) begin
              shift    <= fifo_mem[rd_ptr];
              baud_cnt <= DIV_M1;
              UART_TXD <= 1'b0;
              state    <= START;
            end else begin
              UART_TXD <= 1'b1;
              state    <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - ONE_B;
          end
        end
        default: begin
          UART_TXD <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
